// File: rtl/retrans_pkg.sv
// Shared types and constants for the retransmission controller.
// State encoding is fixed so that it can be read directly in waveforms and debug registers.
package retrans_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SENDING  = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_RETRANS  = 3'd3,
    ST_FAIL     = 3'd4
  } state_t;

  localparam int unsigned STAT_W = 16;

  // Saturating increment for the statistics counters.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/retrans_timer.sv
// ACK timeout down-counter: i_load presets TIMEOUT_CYCLES-1, i_en decrements and holds at zero.
// o_expired is decoded from the registered count, so it is valid one cycle after the load.
module retrans_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] LOAD_VAL = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = LOAD_VAL;
    end else if (i_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expired = (cnt_q == '0);

endmodule

// File: rtl/retrans_ctrl.sv
// Sender-side retransmission controller: gates new frames, waits for ACK/NAK, retransmits on NAK/timeout.
// Outputs decode registered state (one-cycle input-to-output latency). Optional RETRANS_CTRL_STATS_EN builds the counters.
module retrans_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_frame_start,
  input  logic                                 i_frame_end,
  input  logic                                 i_ack_valid,
  input  logic                                 i_ack_ok,
  input  logic                                 i_clr_fail,
  output logic                                 o_send_en,
  output logic                                 o_retrans_req,
  output logic                                 o_busy,
  output logic                                 o_fail,
  output logic [$clog2(MAX_RETRIES+1)-1:0]     o_retry_cnt,
  output logic [15:0]                          o_frame_cnt,
  output logic [15:0]                          o_nak_cnt,
  output logic [15:0]                          o_timeout_cnt
);

  import retrans_pkg::*;

  localparam int unsigned RW = $clog2(MAX_RETRIES + 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

  state_t        state_q, state_d;
  logic [RW-1:0] retry_cnt_q, retry_cnt_d;
  logic          tmr_load;
  logic          tmr_en;
  logic          tmr_expired;

  retrans_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (tmr_load),
    .i_en      (tmr_en),
    .o_expired (tmr_expired)
  );

  always_comb begin
    state_d     = state_q;
    retry_cnt_d = retry_cnt_q;
    tmr_load    = 1'b0;
    tmr_en      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_frame_start) begin
          state_d = ST_SENDING;
        end
      end
      ST_SENDING: begin
        // A new frame_start alongside frame_end is irrelevant: the end closes the frame.
        if (i_frame_end) begin
          state_d  = ST_WAIT_ACK;
          tmr_load = 1'b1;
        end
      end
      ST_WAIT_ACK: begin
        tmr_en = 1'b1;
        if (i_ack_valid && i_ack_ok) begin
          state_d     = ST_IDLE;
          retry_cnt_d = '0;
        end else if (i_ack_valid || tmr_expired) begin
          state_d = (retry_cnt_q == RETRY_MAX) ? ST_FAIL : ST_RETRANS;
        end
      end
      ST_RETRANS: begin
        state_d = ST_SENDING;
        if (retry_cnt_q < RETRY_MAX) begin
          retry_cnt_d = retry_cnt_q + RW'(1);
        end
      end
      ST_FAIL: begin
        if (i_clr_fail) begin
          state_d     = ST_IDLE;
          retry_cnt_d = '0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        retry_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      retry_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      retry_cnt_q <= retry_cnt_d;
    end
  end

  assign o_send_en     = (state_q == ST_IDLE) || (state_q == ST_SENDING);
  assign o_retrans_req = (state_q == ST_RETRANS);
  assign o_busy        = (state_q != ST_IDLE);
  assign o_fail        = (state_q == ST_FAIL);
  assign o_retry_cnt   = retry_cnt_q;

`ifdef RETRANS_CTRL_STATS_EN
  logic              in_wait;
  logic              ack_evt, nak_evt, to_evt;
  logic [STAT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [STAT_W-1:0] nak_cnt_q, nak_cnt_d;
  logic [STAT_W-1:0] timeout_cnt_q, timeout_cnt_d;

  // A status strobe in the expiry cycle takes precedence, so no timeout is counted then.
  assign in_wait = (state_q == ST_WAIT_ACK);
  assign ack_evt = in_wait && i_ack_valid && i_ack_ok;
  assign nak_evt = in_wait && i_ack_valid && !i_ack_ok;
  assign to_evt  = in_wait && !i_ack_valid && tmr_expired;

  always_comb begin
    frame_cnt_d   = ack_evt ? sat_inc(frame_cnt_q)   : frame_cnt_q;
    nak_cnt_d     = nak_evt ? sat_inc(nak_cnt_q)     : nak_cnt_q;
    timeout_cnt_d = to_evt  ? sat_inc(timeout_cnt_q) : timeout_cnt_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      frame_cnt_q   <= '0;
      nak_cnt_q     <= '0;
      timeout_cnt_q <= '0;
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      nak_cnt_q     <= nak_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end

  assign o_frame_cnt   = frame_cnt_q;
  assign o_nak_cnt     = nak_cnt_q;
  assign o_timeout_cnt = timeout_cnt_q;
`else
  assign o_frame_cnt   = '0;
  assign o_nak_cnt     = '0;
  assign o_timeout_cnt = '0;
`endif

endmodule
